// File: rtl/writeback_if.sv
// rtl/writeback_if.sv - Memory-to-Writeback request bus and Writeback result bus
interface writeback_if;
    // Memory-stage result presented to Writeback
    logic        inbubble;
    logic [31:0] pc;
    logic [31:0] insn;
    logic        write_reg;
    logic [3:0]  write_num;
    logic [31:0] write_data;
    logic        cpsr_wr;
    logic [31:0] cpsr;
    logic        spsr_wr;
    logic [31:0] spsr;

    // Writeback results: register file port, status registers, redirect, trace
    logic        regfile_write_req;
    logic [3:0]  regfile_write;
    logic [31:0] regfile_write_data;
    logic [31:0] outcpsr;
    logic        spsr_write;
    logic [31:0] outspsr;
    logic        jmp;
    logic [31:0] jmppc;
    logic        outbubble;
    logic [31:0] outpc;
    logic [31:0] outinsn;
    logic [31:0] retired;

    modport master (
        output inbubble, pc, insn, write_reg, write_num, write_data,
               cpsr_wr, cpsr, spsr_wr, spsr,
        input  regfile_write_req, regfile_write, regfile_write_data, outcpsr,
               spsr_write, outspsr, jmp, jmppc, outbubble, outpc, outinsn, retired
    );

    modport slave (
        input  inbubble, pc, insn, write_reg, write_num, write_data,
               cpsr_wr, cpsr, spsr_wr, spsr,
        output regfile_write_req, regfile_write, regfile_write_data, outcpsr,
               spsr_write, outspsr, jmp, jmppc, outbubble, outpc, outinsn, retired
    );
endinterface

// File: rtl/writeback.sv
// rtl/writeback.sv - commit stage: register/CPSR/SPSR writeback, PC redirect, retire trace
module writeback #(
    parameter logic [31:0] RESET_CPSR    = 32'h000000D3,
    parameter int unsigned SQUASH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        Nrst,
    writeback_if.slave  bus
);
    // Counter wide enough to hold SQUASH_CYCLES (at least one bit so 0 still builds)
    localparam int unsigned SQW = (SQUASH_CYCLES < 2) ? 1 : $clog2(SQUASH_CYCLES + 1);
    localparam logic [SQW-1:0] SQ_LOAD = SQW'(SQUASH_CYCLES);

    logic [SQW-1:0] squash_q, squash_d;
    logic           regfile_write_req_q, regfile_write_req_d;
    logic [3:0]     regfile_write_q, regfile_write_d;
    logic [31:0]    regfile_write_data_q, regfile_write_data_d;
    logic [31:0]    outcpsr_q, outcpsr_d;
    logic           spsr_write_q, spsr_write_d;
    logic [31:0]    outspsr_q, outspsr_d;
    logic           jmp_q, jmp_d;
    logic [31:0]    jmppc_q, jmppc_d;
    logic           outbubble_q, outbubble_d;
    logic [31:0]    outpc_q, outpc_d;
    logic [31:0]    outinsn_q, outinsn_d;
    logic [31:0]    retired_q, retired_d;

    logic commit;
    logic pc_write;

    // An instruction commits only when valid and no redirect shadow is active;
    // a write to r15 is a branch, never a register-file write.
    assign commit   = !bus.inbubble && (squash_q == '0);
    assign pc_write = bus.write_reg && (bus.write_num == 4'd15);

    // Next-state: strobes pulse for one cycle on commit, architectural values hold otherwise
    always_comb begin
        squash_d             = squash_q;
        regfile_write_req_d  = 1'b0;
        regfile_write_d      = regfile_write_q;
        regfile_write_data_d = regfile_write_data_q;
        outcpsr_d            = outcpsr_q;
        spsr_write_d         = 1'b0;
        outspsr_d            = outspsr_q;
        jmp_d                = 1'b0;
        jmppc_d              = jmppc_q;
        outbubble_d          = 1'b1;
        outpc_d              = outpc_q;
        outinsn_d            = outinsn_q;
        retired_d            = retired_q;

        if (squash_q != '0) begin
            squash_d = squash_q - 1'b1;
        end

        if (commit) begin
            outbubble_d = 1'b0;
            outpc_d     = bus.pc;
            outinsn_d   = bus.insn;
            retired_d   = retired_q + 32'd1;

            if (bus.write_reg && !pc_write) begin
                regfile_write_req_d  = 1'b1;
                regfile_write_d      = bus.write_num;
                regfile_write_data_d = bus.write_data;
            end

            if (pc_write) begin
                jmp_d    = 1'b1;
                jmppc_d  = {bus.write_data[31:2], 2'b00};
                squash_d = SQ_LOAD;
            end

            if (bus.cpsr_wr) begin
                outcpsr_d = bus.cpsr;
            end

            if (bus.spsr_wr) begin
                spsr_write_d = 1'b1;
                outspsr_d    = bus.spsr;
            end
        end
    end

    // State register with asynchronous reset to the power-up architectural state
    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            squash_q             <= '0;
            regfile_write_req_q  <= 1'b0;
            regfile_write_q      <= 4'd0;
            regfile_write_data_q <= 32'd0;
            outcpsr_q            <= RESET_CPSR;
            spsr_write_q         <= 1'b0;
            outspsr_q            <= 32'd0;
            jmp_q                <= 1'b0;
            jmppc_q              <= 32'd0;
            outbubble_q          <= 1'b1;
            outpc_q              <= 32'd0;
            outinsn_q            <= 32'd0;
            retired_q            <= 32'd0;
        end else begin
            squash_q             <= squash_d;
            regfile_write_req_q  <= regfile_write_req_d;
            regfile_write_q      <= regfile_write_d;
            regfile_write_data_q <= regfile_write_data_d;
            outcpsr_q            <= outcpsr_d;
            spsr_write_q         <= spsr_write_d;
            outspsr_q            <= outspsr_d;
            jmp_q                <= jmp_d;
            jmppc_q              <= jmppc_d;
            outbubble_q          <= outbubble_d;
            outpc_q              <= outpc_d;
            outinsn_q            <= outinsn_d;
            retired_q            <= retired_d;
        end
    end

    assign bus.regfile_write_req  = regfile_write_req_q;
    assign bus.regfile_write      = regfile_write_q;
    assign bus.regfile_write_data = regfile_write_data_q;
    assign bus.outcpsr            = outcpsr_q;
    assign bus.spsr_write         = spsr_write_q;
    assign bus.outspsr            = outspsr_q;
    assign bus.jmp                = jmp_q;
    assign bus.jmppc              = jmppc_q;
    assign bus.outbubble          = outbubble_q;
    assign bus.outpc              = outpc_q;
    assign bus.outinsn            = outinsn_q;
    assign bus.retired            = retired_q;
endmodule

// File: tb/tb_writeback.sv
// tb/tb_writeback.sv - vector table, random run against a reference model, reset/wrap corners
module tb_writeback;
    localparam int SQ = 2;

    logic clk = 1'b0;
    logic Nrst = 1'b0;
    always #5 clk = ~clk;

    writeback_if wb();

    writeback #(.RESET_CPSR(32'h000000D3), .SQUASH_CYCLES(SQ)) dut (
        .clk  (clk),
        .Nrst (Nrst),
        .bus  (wb.slave)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference state: what the architecture should show after each edge
    int          m_drop;
    logic [31:0] m_retired, m_cpsr, m_spsr, m_pc, m_insn, m_jmppc, m_rf_data;
    logic [3:0]  m_rf_num;
    logic        m_rf_req, m_spsw, m_jmp, m_bub;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_drop = 0; m_retired = 0; m_cpsr = 32'h000000D3; m_spsr = 0;
        m_pc = 0; m_insn = 0; m_jmppc = 0; m_rf_num = 0; m_rf_data = 0;
        m_rf_req = 0; m_spsw = 0; m_jmp = 0; m_bub = 1;
    endtask

    // One edge of architectural behaviour: either the instruction retires with all its
    // side effects, or it vanishes; a taken branch hides the next SQ instructions.
    task automatic model_step();
        bit take;
        take = !wb.inbubble && (m_drop == 0);
        if (m_drop > 0) m_drop--;
        m_rf_req = 0; m_spsw = 0; m_jmp = 0; m_bub = 1;
        if (take) begin
            m_bub = 0; m_pc = wb.pc; m_insn = wb.insn; m_retired = m_retired + 1;
            if (wb.write_reg && wb.write_num == 4'd15) begin
                m_jmp = 1; m_jmppc = wb.write_data & ~32'd3; m_drop = SQ;
            end else if (wb.write_reg) begin
                m_rf_req = 1; m_rf_num = wb.write_num; m_rf_data = wb.write_data;
            end
            if (wb.cpsr_wr) m_cpsr = wb.cpsr;
            if (wb.spsr_wr) begin m_spsw = 1; m_spsr = wb.spsr; end
        end
    endtask

    task automatic compare_all();
        chk("outbubble", {31'd0, wb.outbubble}, {31'd0, m_bub});
        chk("outpc", wb.outpc, m_pc);
        chk("outinsn", wb.outinsn, m_insn);
        chk("rf_req", {31'd0, wb.regfile_write_req}, {31'd0, m_rf_req});
        if (m_rf_req) begin
            chk("rf_num", {28'd0, wb.regfile_write}, {28'd0, m_rf_num});
            chk("rf_data", wb.regfile_write_data, m_rf_data);
        end
        chk("outcpsr", wb.outcpsr, m_cpsr);
        chk("spsr_write", {31'd0, wb.spsr_write}, {31'd0, m_spsw});
        chk("outspsr", wb.outspsr, m_spsr);
        chk("jmp", {31'd0, wb.jmp}, {31'd0, m_jmp});
        chk("jmppc", wb.jmppc, m_jmppc);
        chk("retired", wb.retired, m_retired);
    endtask

    task automatic drive(input logic inb, input logic [31:0] pc, input logic wr,
                         input logic [3:0] num, input logic [31:0] data,
                         input logic cw, input logic [31:0] c,
                         input logic sw, input logic [31:0] s);
        wb.inbubble = inb; wb.pc = pc; wb.insn = 32'hE1A00000 ^ pc;
        wb.write_reg = wr; wb.write_num = num; wb.write_data = data;
        wb.cpsr_wr = cw; wb.cpsr = c; wb.spsr_wr = sw; wb.spsr = s;
    endtask

    task automatic tick();
        @(posedge clk);
        if (Nrst) model_step(); else model_reset();
        #1;
        compare_all();
    endtask

    typedef struct {
        logic        inb;
        logic        wr;
        logic [3:0]  num;
        logic [31:0] data;
        logic        cw;
        logic [31:0] c;
        logic        sw;
        logic [31:0] s;
        logic        e_req;
        logic        e_jmp;
        logic        e_bub;
        logic        e_spsw;
        logic [31:0] e_ret;
        logic [31:0] e_cpsr;
    } vec_t;

    vec_t tbl[11];

    initial begin
        //            inb wr num   data           cw c             sw s             req jmp bub spsw ret cpsr
        tbl[0]  = '{1'b0,1'b1,4'd3, 32'h12345678,1'b0,32'h0,       1'b0,32'h0,       1'b1,1'b0,1'b0,1'b0,32'd1,32'hD3};
        tbl[1]  = '{1'b1,1'b0,4'd0, 32'h0,       1'b0,32'h0,       1'b0,32'h0,       1'b0,1'b0,1'b1,1'b0,32'd1,32'hD3};
        tbl[2]  = '{1'b0,1'b1,4'd15,32'h00008003,1'b0,32'h0,       1'b0,32'h0,       1'b0,1'b1,1'b0,1'b0,32'd2,32'hD3};
        tbl[3]  = '{1'b0,1'b1,4'd1, 32'h11111111,1'b0,32'h0,       1'b0,32'h0,       1'b0,1'b0,1'b1,1'b0,32'd2,32'hD3};
        tbl[4]  = '{1'b0,1'b1,4'd2, 32'h22222222,1'b0,32'h0,       1'b0,32'h0,       1'b0,1'b0,1'b1,1'b0,32'd2,32'hD3};
        tbl[5]  = '{1'b0,1'b1,4'd4, 32'h44444444,1'b0,32'h0,       1'b0,32'h0,       1'b1,1'b0,1'b0,1'b0,32'd3,32'hD3};
        tbl[6]  = '{1'b1,1'b1,4'd5, 32'h55555555,1'b1,32'h10,      1'b1,32'h1F,      1'b0,1'b0,1'b1,1'b0,32'd3,32'hD3};
        tbl[7]  = '{1'b0,1'b1,4'd15,32'h00001000,1'b1,32'h00000010,1'b1,32'h600000D3,1'b0,1'b1,1'b0,1'b1,32'd4,32'h10};
        tbl[8]  = '{1'b1,1'b0,4'd0, 32'h0,       1'b0,32'h0,       1'b0,32'h0,       1'b0,1'b0,1'b1,1'b0,32'd4,32'h10};
        tbl[9]  = '{1'b1,1'b0,4'd0, 32'h0,       1'b0,32'h0,       1'b0,32'h0,       1'b0,1'b0,1'b1,1'b0,32'd4,32'h10};
        tbl[10] = '{1'b0,1'b1,4'd5, 32'hCAFEF00D,1'b0,32'h0,       1'b0,32'h0,       1'b1,1'b0,1'b0,1'b0,32'd5,32'h10};

        model_reset();
        drive(1'b1, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        Nrst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        Nrst = 1'b1;

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].inb, 32'h100 + 32'(i) * 4, tbl[i].wr, tbl[i].num, tbl[i].data,
                  tbl[i].cw, tbl[i].c, tbl[i].sw, tbl[i].s);
            tick();
            chk($sformatf("tbl%0d.req", i), {31'd0, wb.regfile_write_req}, {31'd0, tbl[i].e_req});
            chk($sformatf("tbl%0d.jmp", i), {31'd0, wb.jmp}, {31'd0, tbl[i].e_jmp});
            chk($sformatf("tbl%0d.bub", i), {31'd0, wb.outbubble}, {31'd0, tbl[i].e_bub});
            chk($sformatf("tbl%0d.spsw", i), {31'd0, wb.spsr_write}, {31'd0, tbl[i].e_spsw});
            chk($sformatf("tbl%0d.ret", i), wb.retired, tbl[i].e_ret);
            chk($sformatf("tbl%0d.cpsr", i), wb.outcpsr, tbl[i].e_cpsr);
            if (i == 2) chk("tbl2.jmppc", wb.jmppc, 32'h00008000);
            if (i == 7) chk("tbl7.spsr", wb.outspsr, 32'h600000D3);
        end

        // Randomised traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 1) == 1,
                  4'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, 3) == 0, $urandom,
                  $urandom_range(0, 3) == 0, $urandom);
            tick();
        end

        // Let any squash shadow drain, then reset right after a PC-write commit
        drive(1'b1, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (3) tick();
        drive(1'b0, 32'h2000, 1'b1, 4'd15, 32'h00004002, 1'b1, 32'h1F, 1'b0, 32'h0);
        tick();
        chk("pre_rst.jmp", {31'd0, wb.jmp}, 32'd1);
        drive(1'b0, 32'h2004, 1'b1, 4'd6, 32'h66666666, 1'b0, 32'h0, 1'b0, 32'h0);
        Nrst = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("rst.jmp", {31'd0, wb.jmp}, 32'd0);
        chk("rst.cpsr", wb.outcpsr, 32'h000000D3);
        @(negedge clk);
        Nrst = 1'b1;
        tick();
        chk("post_rst.bub", {31'd0, wb.outbubble}, 32'd0);
        chk("post_rst.req", {31'd0, wb.regfile_write_req}, 32'd1);
        chk("post_rst.ret", wb.retired, 32'd1);

        // Retire counter wrap
        drive(1'b1, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        force dut.retired_q = 32'hFFFFFFFF;
        #1;
        release dut.retired_q;
        m_retired = 32'hFFFFFFFF;
        drive(1'b0, 32'h3000, 1'b1, 4'd7, 32'h77777777, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        chk("wrap.ret", wb.retired, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/writeback.md
WRITEBACK -- requirements
Module: Writeback

Interface
REQ-001 Parameter: RESET_CPSR, 32'h000000D3, CPSR value loaded at reset (SVC mode, IRQ/FIQ masked).
REQ-002 Parameter: SQUASH_CYCLES, 2, cycles after a committed PC write during which incoming instructions are discarded.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 Nrst  input  1  reset, asynchronous, active-low.
REQ-005 inbubble  input  1  high = no valid instruction from Memory this cycle.
REQ-006 pc, insn  input  32 each  PC and instruction of the Memory-stage result.
REQ-007 write_reg, write_num, write_data  input  1/4/32  register writeback request, destination, value (Memory out_write_*).
REQ-008 cpsr_wr, cpsr  input  1/32  CPSR update request and new value.
REQ-009 spsr_wr, spsr  input  1/32  SPSR update request and new value.
REQ-010 regfile_write_req, regfile_write, regfile_write_data  output  1/4/32  RegFile write port.
REQ-011 outcpsr  output  32  architectural CPSR.
REQ-012 spsr_write, outspsr  output  1/32  SPSR write strobe and value to RegFile.
REQ-013 jmp, jmppc  output  1/32  redirect to Fetch on committed PC write.
REQ-014 outbubble, outpc, outinsn  output  1/32/32  retired-instruction trace.
REQ-015 retired  output  32  count of committed instructions.

Function
REQ-016 All outputs registered; one-cycle latency from inputs to outputs.
REQ-017 Commit condition: inbubble=0 and squash counter = 0; else input is dropped and outbubble=1 next cycle.
REQ-018 On commit with write_reg=1 and write_num!=15: regfile_write_req=1, regfile_write=write_num, regfile_write_data=write_data for exactly one cycle.
REQ-019 On commit with write_reg=1 and write_num=15: regfile_write_req=0; jmp=1 for one cycle; jmppc=write_data with bits [1:0] cleared; squash counter loaded with SQUASH_CYCLES.
REQ-020 Squash counter decrements by 1 each cycle while nonzero, regardless of inbubble; saturates at 0.
REQ-021 On commit with cpsr_wr=1: outcpsr<=cpsr next cycle; otherwise outcpsr holds.
REQ-022 On commit with spsr_wr=1: spsr_write=1 one cycle, outspsr<=spsr; outspsr holds otherwise.
REQ-023 PC write, CPSR write, SPSR write in the same commit all take effect on the same edge (e.g. MOVS pc, lr).
REQ-024 On commit: outbubble=0, outpc=pc, outinsn=insn, retired+1; retired wraps from 32'hFFFFFFFF to 0.
REQ-025 On non-commit: outbubble=1, all write strobes and jmp 0; outpc/outinsn/outcpsr/outspsr/jmppc hold.
REQ-026 write_reg/cpsr_wr/spsr_wr are ignored when inbubble=1 or squashing.
REQ-027 SQUASH_CYCLES=0: no instruction discarded after a PC write.

Reset
REQ-028 Nrst low asynchronously forces: regfile_write_req=0, regfile_write=0, regfile_write_data=0, outcpsr=RESET_CPSR, spsr_write=0, outspsr=0, jmp=0, jmppc=0, outbubble=1, outpc=0, outinsn=0, retired=0, squash counter=0.
REQ-029 Reset asserted mid-squash or mid-write cancels all pending strobes; first post-reset commit behaves as from power-up.

Verification
REQ-030 Reset, then commit write_num=3, data 32'h12345678 -> next cycle regfile_write_req=1, regfile_write=3, data 32'h12345678, retired=1; strobe low the cycle after.
REQ-031 Commit write_num=15, data 32'h00008003 followed by two valid instructions writing r1, r2 -> jmp=1, jmppc=32'h00008000 one cycle; r1, r2 writes dropped, outbubble=1 twice; third instruction commits, retired=2.
REQ-032 Commit write_num=15, cpsr_wr=1, cpsr=32'h00000010, spsr_wr=1, spsr=32'h600000D3 -> same cycle jmp=1, outcpsr=32'h00000010, spsr_write=1, outspsr=32'h600000D3.
REQ-033 inbubble=1 with write_reg=1, cpsr_wr=1 -> no strobes, outcpsr unchanged at 32'h000000D3, retired unchanged.
REQ-034 Force retired to 32'hFFFFFFFF (by commits or backdoor), commit one -> retired=0.
REQ-035 Drive Nrst low one cycle after a PC-write commit -> jmp, squash counter, regfile_write_req immediately 0, outcpsr=32'h000000D3; next valid instruction after release commits.
